// File: rtl/muldiv_unit.sv
// Iterative MIPS32 HI/LO multiply/divide: radix-2 shift-add / restoring divide, one op in flight.
// Fixed latency: accept edge, 32 RUN steps, one FIX edge; start while busy is dropped.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] mt_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic               dz_q, dz_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_rem;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;

  always_comb begin
    // op[0]=0 selects the signed variants
    a_neg    = ~op[0] & rs_val[WIDTH-1];
    b_neg    = ~op[0] & rt_val[WIDTH-1];
    a_mag    = a_neg ? -rs_val : rs_val;
    b_mag    = b_neg ? -rt_val : rt_val;

    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_rem  = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff = div_rem - {1'b0, opnd_q};
    div_ge   = (div_rem >= {1'b0, opnd_q});

    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_raw_d  = a_raw_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    dz_d     = dz_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d     = op;
          a_raw_d  = rs_val;
          opnd_d   = op[1] ? b_mag : a_mag;
          acc_d    = {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
          neg_lo_d = a_neg ^ b_neg;
          neg_hi_d = a_neg;
          dz_d     = op[1] & (rt_val == '0);
          dbz_d    = 1'b0;
          cnt_d    = '0;
          state_d  = RUN;
        end else begin
          if (mthi) hi_d = mt_data;
          if (mtlo) lo_d = mt_data;
        end
      end
      RUN: begin
        // Divide: remainder in the upper half, quotient bits shift in at the bottom.
        if (op_q[1])
          acc_d = {(div_ge ? div_diff[WIDTH-1:0] : div_rem[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
        else
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
      end
      FIX: begin
        if (op_q[1]) begin
          if (dz_q) begin
            lo_d = '1;
            hi_d = a_raw_q;
          end else begin
            lo_d = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
            hi_d = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
          end
        end else begin
          {hi_d, lo_d} = neg_lo_q ? -acc_q : acc_q;
        end
        dbz_d   = dz_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_raw_q  <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_raw_q  <= a_raw_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      dz_q     <= dz_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 32-bit multiply/divide unit with architectural HI/LO registers for the MIPS32 datapath. It consumes the two operands read from the register file (rs/rt read ports) for MULT, MULTU, DIV and DIVU. It produces HI/LO, which the writeback path returns to the register file via MFHI/MFLO. One operation is in flight at a time, at a fixed 34-cycle latency, using a radix-2 shift-add/restoring-subtract datapath.

## Interface
- WIDTH, 32, operand width; HI and LO are each WIDTH bits. Only 32 is verified.
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  launch request; accepted only on an edge where busy=0
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
- rs_val  in  32  operand A (multiplicand/dividend), from register file read port 1
- rt_val  in  32  operand B (multiplier/divisor), from register file read port 2
- mthi  in  1  write mt_data into HI (MTHI)
- mtlo  in  1  write mt_data into LO (MTLO)
- mt_data  in  32  data for mthi/mtlo
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse; HI/LO hold the new result
- div_by_zero  out  1  valid with done; 1 for DIV/DIVU with rt_val=0
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- States: IDLE, RUN, FIX.
- IDLE, start=1:
  - Latch op, rs_val and rt_val; later operand changes have no effect.
  - For signed ops, latch the operand magnitudes and the result signs.
  - Clear the step counter and go to RUN.
- RUN: one radix-2 step per cycle over 32 steps, counter 0..31. After step 31, go to FIX.
- FIX: apply the sign correction, write HI/LO, pulse done, go to IDLE.
- MULT/MULTU: {HI,LO} = full 64-bit product, signed or unsigned.
- DIV/DIVU:
  - LO = quotient, truncated toward zero.
  - HI = remainder, with the sign of the dividend (signed case).
- Signed overflow, 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero: no sign fix is applied. LO=0xFFFFFFFF, HI=original rs_val, div_by_zero=1. The full latency still applies.
- hi/lo keep their previous values throughout RUN and change only in FIX.
- mthi/mtlo:
  - Honoured only when busy=0 and start=0; otherwise ignored.
  - mthi and mtlo together write the same mt_data to both.
- start while busy=1 is ignored; there is no queueing.
- start and mthi/mtlo on the same idle edge: start wins and mt writes are dropped.
- div_by_zero is cleared on the next accepted start.

## Timing
- Reset values: state IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, counter=0.
- Reset mid-operation aborts the operation with no HI/LO update.
- Let E0 be the edge that accepts start.
  - busy=1 after E0.
  - RUN steps occur on E1..E32.
  - FIX occurs on E33: hi/lo/div_by_zero update, done=1 and busy=0 for the cycle following E33.
- Result latency: 34 edges from start acceptance to HI/LO visible.
- Back-to-back: start asserted in the done cycle is accepted at E34, with no bubble.
- mthi/mtlo take effect on the sampling edge; hi/lo are visible the next cycle.
- done is never high for more than one cycle; busy and done are never both high.

## Test plan
- Reset, then idle for 5 cycles -> hi=0, lo=0, busy=0, done=0. Then mthi with mt_data=0x12345678 -> hi=0x12345678 one cycle later.
- Multiply, rs=0xFFFFFFFF, rt=2:
  - MULT -> hi=0xFFFFFFFF, lo=0xFFFFFFFE, with done exactly 34 edges after start.
  - MULTU -> hi=0x00000001, lo=0xFFFFFFFE.
- Divide:
  - DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU rs=7, rt=2 -> lo=3, hi=1.
  - DIV rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU rs=5, rt=0 -> lo=0xFFFFFFFF, hi=5, div_by_zero=1 with done. A following MULTU 3*3 -> div_by_zero=0, lo=9, hi=0.
- During a MULT of 3*4:
  - Start a DIV at cycle 5 -> ignored.
  - mtlo at cycle 6 -> ignored.
  - Result hi=0, lo=12.
  - New start in the done cycle is accepted, and its result appears 34 edges later.
- Reset asserted at RUN step 10 of MULT 3*4, with prior hi/lo=0xAAAA_AAAA -> next cycle busy=0, hi=lo=0, and no done pulse.
